keypad_scan_sequencer: RTL and testbench

- Single FSM that sequences the 4x4 keypad.
- Drives the one-hot row strobe, synchronizes the raw column inputs, waits a settle window per row, debounces press and release, and emits one registered pulse per accepted key.
- Sits between the keypad pins and the decoder/controller, and replaces the separate scan and debounce stages.
- Output format is row/col one-hot active-high, matching the decoder input.

---
 rtl/keypad_scan_sequencer.sv | 157 +++++++++++++++
 tb/tb_keypad_scan_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_sequencer.sv
// keypad_scan_sequencer: one FSM that strobes the 4x4 keypad rows,
// synchronizes and debounces the columns, and pulses once per accepted key.
module keypad_scan_sequencer #(
    parameter int SETTLE_CYCLES   = 8,
    parameter int DEBOUNCE_CYCLES = 60000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic       key_held,
    output logic       scan_active
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [CW-1:0] SETTLE_LAST   = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DEBOUNCE_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_SCAN,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    state_t        state_q;
    logic [1:0]    row_ptr_q;
    logic [3:0]    row_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    sync1_q;
    logic [3:0]    sync2_q;
    logic [3:0]    cap_col_q;
    logic [1:0]    cap_row_q;
    logic          key_valid_q;
    logic [3:0]    key_row_q;
    logic [3:0]    key_col_q;
    logic          key_held_q;
    logic          scan_active_q;

    logic [3:0]    col_low_d;
    logic          one_low_d;
    logic          cap_match_d;
    logic          cap_high_d;

    // Column decode of the synchronized (active-low) inputs.
    always_comb begin
        col_low_d   = ~sync2_q;
        one_low_d   = (col_low_d != 4'd0) &&
                      ((col_low_d & (col_low_d - 4'd1)) == 4'd0);
        cap_match_d = (col_low_d == cap_col_q);
        cap_high_d  = |(sync2_q & cap_col_q);
    end

    // Two-flop synchronizer; idle columns read high (pull-ups).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= col;
            sync2_q <= sync1_q;
        end
    end

    // Scan / debounce / hold / release sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_SCAN;
            row_ptr_q     <= 2'd0;
            row_q         <= 4'b1110;
            cnt_q         <= '0;
            cap_col_q     <= 4'd0;
            cap_row_q     <= 2'd0;
            key_valid_q   <= 1'b0;
            key_row_q     <= 4'd0;
            key_col_q     <= 4'd0;
            key_held_q    <= 1'b0;
            scan_active_q <= 1'b1;
        end else begin
            key_valid_q <= 1'b0;
            unique case (state_q)
                S_SCAN: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q <= '0;
                        if (one_low_d) begin
                            cap_col_q     <= col_low_d;
                            cap_row_q     <= row_ptr_q;
                            state_q       <= S_DEBOUNCE;
                            scan_active_q <= 1'b0;
                        end else begin
                            row_ptr_q <= row_ptr_q + 2'd1;
                            row_q     <= {row_q[2:0], row_q[3]};
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DEBOUNCE: begin
                    if (!cap_match_d) begin
                        state_q       <= S_SCAN;
                        cnt_q         <= '0;
                        row_ptr_q     <= row_ptr_q + 2'd1;
                        row_q         <= {row_q[2:0], row_q[3]};
                        scan_active_q <= 1'b1;
                    end else if (cnt_q == DEBOUNCE_LAST) begin
                        state_q     <= S_HELD;
                        cnt_q       <= '0;
                        key_valid_q <= 1'b1;
                        key_row_q   <= 4'b0001 << cap_row_q;
                        key_col_q   <= cap_col_q;
                        key_held_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_HELD: begin
                    if (cap_high_d) begin
                        state_q <= S_RELEASE;
                        cnt_q   <= '0;
                    end
                end
                S_RELEASE: begin
                    if (!cap_high_d) begin
                        state_q <= S_HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == DEBOUNCE_LAST) begin
                        state_q       <= S_SCAN;
                        cnt_q         <= '0;
                        row_ptr_q     <= row_ptr_q + 2'd1;
                        row_q         <= {row_q[2:0], row_q[3]};
                        key_held_q    <= 1'b0;
                        scan_active_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q       <= S_SCAN;
                    cnt_q         <= '0;
                    scan_active_q <= 1'b1;
                end
            endcase
        end
    end

    assign row         = row_q;
    assign key_valid   = key_valid_q;
    assign key_row     = key_row_q;
    assign key_col     = key_col_q;
    assign key_held    = key_held_q;
    assign scan_active = scan_active_q;

endmodule

// File: tb/tb_keypad_scan_sequencer.sv
// tb_keypad_scan_sequencer: keypad model plus scoreboard of expected keys,
// checked against each key_valid pulse.
module tb_keypad_scan_sequencer;

    localparam int SC = 4;
    localparam int DC = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] row;
    logic [3:0] col;
    logic       key_valid;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic       key_held;
    logic       scan_active;

    logic [15:0] keys = 16'd0;

    logic [7:0] exp_q[$];
    int n_tests   = 0;
    int n_fail    = 0;
    int pulse_cnt = 0;
    logic prev_valid = 1'b0;

    keypad_scan_sequencer #(
        .SETTLE_CYCLES  (SC),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .row        (row),
        .col        (col),
        .key_valid  (key_valid),
        .key_row    (key_row),
        .key_col    (key_col),
        .key_held   (key_held),
        .scan_active(scan_active)
    );

    always #5 clk = ~clk;

    // Pressed key (r,c) pulls column c low while row r is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && (row[r] == 1'b0))
                    col[c] = 1'b0;
    end

    // Scoreboard: each pulse pops one expected {row,col}.
    always @(negedge clk) begin
        logic [7:0] e;
        if (key_valid === 1'b1) begin
            pulse_cnt++;
            n_tests++;
            if (prev_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL valid_consec: got %b exp 0", prev_valid);
            end
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse: got row %b col %b exp none",
                         key_row, key_col);
            end else begin
                e = exp_q.pop_front();
                if ({key_row, key_col} !== e) begin
                    n_fail++;
                    $display("FAIL key_code: got %b_%b exp %b_%b",
                             key_row, key_col, e[7:4], e[3:0]);
                end
            end
        end
        prev_valid = key_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        logic [3:0] e;
        rst_n = 1'b0;
        keys  = 16'd0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (row !== 4'b1110) begin
            n_fail++; $display("FAIL rst_row: got %b exp 1110", row);
        end
        n_tests++;
        if (key_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_valid: got %b exp 0", key_valid);
        end
        n_tests++;
        if (key_row !== 4'd0 || key_col !== 4'd0) begin
            n_fail++;
            $display("FAIL rst_key: got %b_%b exp 0000_0000", key_row, key_col);
        end
        n_tests++;
        if (key_held !== 1'b0 || scan_active !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_flags: got held %b scan %b exp 0 1",
                     key_held, scan_active);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            e = 4'b0001 << ((k / 4) % 4);
            e = ~e;
            n_tests++;
            if (row !== e) begin
                n_fail++;
                $display("FAIL scan_row[%0d]: got %b exp %b", k, row, e);
            end
        end
    endtask

    task automatic test_clean_press();
        int p0, bad, k;
        logic seen;
        p0   = pulse_cnt;
        bad  = 0;
        seen = 1'b0;
        exp_q.push_back({4'b0010, 4'b0100});
        keys = 16'd0;
        keys[1*4+2] = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (key_held === 1'b1) begin
                seen = 1'b1;
                if (row !== 4'b1101) bad++;
            end else if (seen) begin
                bad++;
            end
        end
        n_tests++;
        if (seen !== 1'b1) begin
            n_fail++; $display("FAIL press_held: got %b exp 1", seen);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL press_frozen: got %0d bad exp 0", bad);
        end
        keys = 16'd0;
        k = 0;
        while (key_held === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k < 18 || k > 19) begin
            n_fail++; $display("FAIL release_time: got %0d exp 18..19", k);
        end
        n_tests++;
        if (row !== 4'b1011 || scan_active !== 1'b1) begin
            n_fail++;
            $display("FAIL resume_row: got %b scan %b exp 1011 1",
                     row, scan_active);
        end
        n_tests++;
        if (key_row !== 4'b0010 || key_col !== 4'b0100) begin
            n_fail++;
            $display("FAIL retain_key: got %b_%b exp 0010_0100",
                     key_row, key_col);
        end
        n_tests++;
        if (pulse_cnt - p0 != 1) begin
            n_fail++;
            $display("FAIL press_pulses: got %0d exp 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_press_bounce();
        int p0, k;
        logic found, dbg;
        logic [3:0] prevr;
        p0    = pulse_cnt;
        keys  = 16'd0;
        found = 1'b0;
        dbg   = 1'b0;
        prevr = row;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (row === 4'b0111 && prevr !== 4'b0111) found = 1'b1;
            prevr = row;
        end
        n_tests++;
        if (found !== 1'b1) begin
            n_fail++; $display("FAIL bounce_row3: got %b exp 1", found);
        end
        keys[3*4+0] = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (scan_active === 1'b0) dbg = 1'b1;
        end
        keys = 16'd0;
        k = 0;
        while (scan_active !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (dbg !== 1'b1) begin
            n_fail++; $display("FAIL bounce_debounce: got %b exp 1", dbg);
        end
        n_tests++;
        if (scan_active !== 1'b1 || row !== 4'b1110) begin
            n_fail++;
            $display("FAIL bounce_back: got %b scan %b exp 1110 1",
                     row, scan_active);
        end
        n_tests++;
        if (pulse_cnt != p0) begin
            n_fail++;
            $display("FAIL bounce_pulses: got %0d exp 0", pulse_cnt - p0);
        end
    endtask

    task automatic test_release_bounce();
        int p0, k, bad;
        p0  = pulse_cnt;
        bad = 0;
        exp_q.push_back({4'b0001, 4'b1000});
        keys = 16'd0;
        keys[0*4+3] = 1'b1;
        k = 0;
        while (key_held !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (key_held !== 1'b1) begin
            n_fail++; $display("FAIL rb_held: got %b exp 1", key_held);
        end
        keys = 16'd0;
        repeat (5) begin
            @(negedge clk);
            if (key_held !== 1'b1) bad++;
        end
        keys[0*4+3] = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (key_held !== 1'b1) bad++;
        end
        keys = 16'd0;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL rb_stay_held: got %0d drops exp 0", bad);
        end
        k = 0;
        while (key_held === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (key_held !== 1'b0) begin
            n_fail++; $display("FAIL rb_drop: got %b exp 0", key_held);
        end
        n_tests++;
        if (pulse_cnt - p0 != 1) begin
            n_fail++;
            $display("FAIL rb_pulses: got %0d exp 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_multi_key();
        int p0, bad;
        logic seen_r2, seen_r0;
        p0      = pulse_cnt;
        bad     = 0;
        seen_r2 = 1'b0;
        seen_r0 = 1'b0;
        keys    = 16'd0;
        keys[2*4+0] = 1'b1;
        keys[2*4+1] = 1'b1;
        repeat (48) begin
            @(negedge clk);
            if (scan_active !== 1'b1) bad++;
            if (row === 4'b1011) seen_r2 = 1'b1;
            if (row === 4'b1110) seen_r0 = 1'b1;
        end
        keys = 16'd0;
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL multi_scan: got %0d exits exp 0", bad);
        end
        n_tests++;
        if (!(seen_r2 && seen_r0)) begin
            n_fail++;
            $display("FAIL multi_cycle: got r2 %b r0 %b exp 1 1",
                     seen_r2, seen_r0);
        end
        n_tests++;
        if (pulse_cnt != p0) begin
            n_fail++;
            $display("FAIL multi_pulses: got %0d exp 0", pulse_cnt - p0);
        end
    endtask

    task automatic test_reset_mid_debounce();
        int p0, k;
        p0   = pulse_cnt;
        keys = 16'd0;
        keys[0] = 1'b1;
        k = 0;
        while (scan_active !== 1'b0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (scan_active !== 1'b0) begin
            n_fail++; $display("FAIL rmd_enter: got %b exp 0", scan_active);
        end
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (row !== 4'b1110 || scan_active !== 1'b1) begin
            n_fail++;
            $display("FAIL rmd_row: got %b scan %b exp 1110 1",
                     row, scan_active);
        end
        n_tests++;
        if ({key_valid, key_held, key_row, key_col} !== 10'd0) begin
            n_fail++;
            $display("FAIL rmd_outs: got v%b h%b %b_%b exp all 0",
                     key_valid, key_held, key_row, key_col);
        end
        n_tests++;
        if (pulse_cnt != p0) begin
            n_fail++;
            $display("FAIL rmd_nopulse: got %0d exp 0", pulse_cnt - p0);
        end
        rst_n = 1'b1;
        exp_q.push_back({4'b0001, 4'b0001});
        k = 0;
        while (key_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (k != SC + DC) begin
            n_fail++;
            $display("FAIL rmd_latency: got %0d exp %0d", k, SC + DC);
        end
        keys = 16'd0;
        k = 0;
        while (key_held === 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (key_held !== 1'b0) begin
            n_fail++; $display("FAIL rmd_release: got %b exp 0", key_held);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_multi_key();
        test_reset_mid_debounce();
        repeat (4) @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d exp 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
